// File: rtl/capture_pkg.sv
//------------------------------------------------------------------------------
// Module      : capture_pkg
// Description : Shared widths, FSM encoding and buffer-slot address helper for
//               the DDR capture sequencer.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package capture_pkg;

   localparam int ADX_W         = 27;
   localparam int DATA_W        = 128;
   localparam int WORD_ADX_STEP = 8;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_PRETRIG  = 3'd1,
      ST_POSTTRIG = 3'd2,
      ST_DRAIN    = 3'd3,
      ST_DONE     = 3'd4,
      ST_READBACK = 3'd5,
      ST_RB_WAIT  = 3'd6
   } cap_state_t;

   // Each 128-bit slot spans WORD_ADX_STEP DDR word addresses.
   function automatic logic [ADX_W-1:0] slot_adx(input logic [ADX_W-1:0] base,
                                                 input logic [ADX_W-1:0] slot);
      return base + slot * ADX_W'(WORD_ADX_STEP);
   endfunction

endpackage

`default_nettype wire

// File: rtl/ddr_capture_sequencer_if.sv
//------------------------------------------------------------------------------
// Module      : ddr_capture_sequencer_if
// Description : Write/read command ports between the capture sequencer
//               (master) and the DDR2 memory interface (slave).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface ddr_capture_sequencer_if;
   import capture_pkg::*;

   logic [ADX_W-1:0]  wr_adx_out;
   logic [DATA_W-1:0] wr_data_out;
   logic              write_req;
   logic              write_allowed;
   logic              writes_pending;
   logic [ADX_W-1:0]  rd_adx_out;
   logic              read_req;
   logic              read_allowed;
   logic              reads_pending;

   modport master (
      output wr_adx_out, wr_data_out, write_req, rd_adx_out, read_req,
      input  write_allowed, writes_pending, read_allowed, reads_pending
   );

   modport slave (
      input  wr_adx_out, wr_data_out, write_req, rd_adx_out, read_req,
      output write_allowed, writes_pending, read_allowed, reads_pending
   );

endinterface

`default_nettype wire

// File: rtl/capture_wr_stage.sv
//------------------------------------------------------------------------------
// Module      : capture_wr_stage
// Description : One-entry write holding register with sample accept/drop
//               decision and the write_req/write_allowed handshake.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module capture_wr_stage
   import capture_pkg::*;
#(
   parameter logic [ADX_W-1:0] BASE_ADX = '0
) (
   input  wire logic              clk,
   input  wire logic              resetn,
   input  wire logic              flush,
   input  wire logic              enable,
   input  wire logic              smp_valid,
   input  wire logic [DATA_W-1:0] smp_data,
   input  wire logic [ADX_W-1:0]  slot_adx_in,
   input  wire logic              write_allowed,
   output logic                   accept,
   output logic                   drop,
   output logic                   write_req,
   output logic [ADX_W-1:0]       wr_adx_out,
   output logic [DATA_W-1:0]      wr_data_out
);

   logic              r_full;
   logic [ADX_W-1:0]  r_adx;
   logic [DATA_W-1:0] r_data;
   logic              w_xfer;

   // A word may enter while the current one is leaving, giving 1 word/cycle.
   assign w_xfer = r_full && write_allowed;
   assign accept = enable && smp_valid && (!r_full || w_xfer);
   assign drop   = enable && smp_valid && !accept;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_full <= 1'b0;
         r_adx  <= BASE_ADX;
         r_data <= '0;
      end else if (flush) begin
         r_full <= 1'b0;
      end else if (accept) begin
         r_full <= 1'b1;
         r_adx  <= slot_adx_in;
         r_data <= smp_data;
      end else if (w_xfer) begin
         r_full <= 1'b0;
      end
   end

   assign write_req   = r_full;
   assign wr_adx_out  = r_adx;
   assign wr_data_out = r_data;

endmodule

`default_nettype wire

// File: rtl/ddr_capture_sequencer.sv
//------------------------------------------------------------------------------
// Module      : ddr_capture_sequencer
// Description : Streams capture samples into a circular DDR buffer, handles
//               trigger/post-trigger counting and drain, then replays the
//               buffer oldest-first. CAPTURE_DROP_COUNT_EN enables drop_count.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ddr_capture_sequencer
   import capture_pkg::*;
#(
   parameter int               BUF_LOG2 = 20,
   parameter logic [ADX_W-1:0] BASE_ADX = 27'h0
) (
   input  wire logic              clk,
   input  wire logic              resetn,
   input  wire logic              arm,
   input  wire logic              abort,
   input  wire logic [BUF_LOG2:0] post_count,
   input  wire logic [DATA_W-1:0] smp_data,
   input  wire logic              smp_valid,
   input  wire logic              trigger,
   input  wire logic              rb_start,
   ddr_capture_sequencer_if.master mem,
   output logic [2:0]             state,
   output logic                   overflow,
   output logic [ADX_W-1:0]       trig_adx,
   output logic [BUF_LOG2:0]      rb_len,
   output logic                   rb_done,
   output logic [15:0]            drop_count
);

   localparam logic [BUF_LOG2:0] c_full_len = {1'b1, {BUF_LOG2{1'b0}}};

   cap_state_t          r_state, w_state_nxt;
   logic [BUF_LOG2-1:0] r_wr_ptr, r_rd_ptr, r_rb_base, w_rd_ptr_nxt;
   logic [BUF_LOG2:0]   r_post_cnt, r_post_rem, r_rb_len, r_rd_rem;
   logic [BUF_LOG2:0]   w_post_rem0, w_rd_rem_nxt;
   logic [ADX_W-1:0]    r_trig_adx, r_rd_adx, w_wr_slot_adx;
   logic                r_wrapped, r_overflow, r_read_req, r_rb_done;
   logic                w_capturing, w_accept, w_drop, w_write_req;
   logic                w_arm_ok, w_rb_go, w_rd_xfer, w_trig_hit;

   assign w_capturing   = (r_state == ST_PRETRIG || r_state == ST_POSTTRIG) && !abort;
   assign w_arm_ok      = arm && (r_state == ST_IDLE || r_state == ST_DONE);
   assign w_rb_go       = rb_start && !arm && (r_state == ST_DONE);
   assign w_rd_xfer     = r_read_req && mem.read_allowed;
   assign w_rd_ptr_nxt  = r_rd_ptr + 1'b1;
   assign w_rd_rem_nxt  = r_rd_rem - 1'b1;
   assign w_post_rem0   = (r_post_cnt == '0) ? '0 : r_post_cnt - 1'b1;
   assign w_trig_hit    = (r_state == ST_PRETRIG) && w_accept && trigger;
   assign w_wr_slot_adx = slot_adx(BASE_ADX, ADX_W'(r_wr_ptr));

   capture_wr_stage #(.BASE_ADX(BASE_ADX)) u_wr_stage (
      .clk          (clk),
      .resetn       (resetn),
      .flush        (abort),
      .enable       (w_capturing),
      .smp_valid    (smp_valid),
      .smp_data     (smp_data),
      .slot_adx_in  (w_wr_slot_adx),
      .write_allowed(mem.write_allowed),
      .accept       (w_accept),
      .drop         (w_drop),
      .write_req    (w_write_req),
      .wr_adx_out   (mem.wr_adx_out),
      .wr_data_out  (mem.wr_data_out)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) r_state <= ST_IDLE;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (abort) begin
         w_state_nxt = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE:     if (arm) w_state_nxt = ST_PRETRIG;
            ST_PRETRIG:  if (w_trig_hit)
                            w_state_nxt = (w_post_rem0 == '0) ? ST_DRAIN : ST_POSTTRIG;
            ST_POSTTRIG: if (w_accept && r_post_rem == 1) w_state_nxt = ST_DRAIN;
            ST_DRAIN:    if (!w_write_req && !mem.writes_pending) w_state_nxt = ST_DONE;
            ST_DONE:     if (arm) w_state_nxt = ST_PRETRIG;
                         else if (rb_start)
                            w_state_nxt = (r_rb_len == '0) ? ST_RB_WAIT : ST_READBACK;
            ST_READBACK: if (w_rd_xfer && w_rd_rem_nxt == '0) w_state_nxt = ST_RB_WAIT;
            ST_RB_WAIT:  if (!mem.reads_pending) w_state_nxt = ST_DONE;
            default:     w_state_nxt = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_wr_ptr   <= '0;
         r_wrapped  <= 1'b0;
         r_overflow <= 1'b0;
         r_post_cnt <= '0;
         r_post_rem <= '0;
         r_trig_adx <= BASE_ADX;
         r_rb_base  <= '0;
         r_rb_len   <= '0;
         r_rd_ptr   <= '0;
         r_rd_rem   <= '0;
         r_rd_adx   <= BASE_ADX;
         r_read_req <= 1'b0;
         r_rb_done  <= 1'b0;
      end else begin
         r_rb_done <= 1'b0;
         if (abort) begin
            r_read_req <= 1'b0;
         end else begin
            if (w_arm_ok) begin
               r_wr_ptr   <= '0;
               r_wrapped  <= 1'b0;
               r_overflow <= 1'b0;
               r_post_cnt <= post_count;
            end
            if (w_accept) begin
               r_wr_ptr <= r_wr_ptr + 1'b1;
               if (&r_wr_ptr) r_wrapped <= 1'b1;
            end
            if (w_drop) r_overflow <= 1'b1;
            if (w_trig_hit) begin
               r_trig_adx <= w_wr_slot_adx;
               r_post_rem <= w_post_rem0;
            end else if (r_state == ST_POSTTRIG && w_accept) begin
               r_post_rem <= r_post_rem - 1'b1;
            end
            // Oldest word sits at the write pointer once the buffer has wrapped.
            if (r_state == ST_DRAIN && w_state_nxt == ST_DONE) begin
               r_rb_base <= r_wrapped ? r_wr_ptr : '0;
               r_rb_len  <= r_wrapped ? c_full_len : {1'b0, r_wr_ptr};
            end
            if (w_rb_go) begin
               r_rd_ptr   <= r_rb_base;
               r_rd_rem   <= r_rb_len;
               r_read_req <= (r_rb_len != '0);
               r_rd_adx   <= slot_adx(BASE_ADX, ADX_W'(r_rb_base));
            end else if (r_state == ST_READBACK && w_rd_xfer) begin
               r_rd_ptr   <= w_rd_ptr_nxt;
               r_rd_rem   <= w_rd_rem_nxt;
               r_read_req <= (w_rd_rem_nxt != '0);
               r_rd_adx   <= slot_adx(BASE_ADX, ADX_W'(w_rd_ptr_nxt));
            end
            if (r_state == ST_RB_WAIT && !mem.reads_pending) r_rb_done <= 1'b1;
         end
      end
   end

`ifdef CAPTURE_DROP_COUNT_EN
   logic [15:0] r_drop_count;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_drop_count <= '0;
      end else if (!abort) begin
         if (w_arm_ok)                               r_drop_count <= '0;
         else if (w_drop && r_drop_count != 16'hFFFF) r_drop_count <= r_drop_count + 1'b1;
      end
   end

   assign drop_count = r_drop_count;
`else
   assign drop_count = '0;
`endif

   assign state        = r_state;
   assign overflow     = r_overflow;
   assign trig_adx     = r_trig_adx;
   assign rb_len       = r_rb_len;
   assign rb_done      = r_rb_done;
   assign mem.write_req  = w_write_req;
   assign mem.read_req   = r_read_req;
   assign mem.rd_adx_out = r_rd_adx;

endmodule

`default_nettype wire
